// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller: owns PC and IR, shares the single RAM port
// between fetch and LDR/STR, and commits each instruction exactly once.
module instr_sequencer #(
   parameter int PC_W  = 8,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [31:0]      Ram_Out,
   input  logic [15:0]      Mem_Address,
   input  logic [3:0]       New_Flag,
   output logic             Ram_Enable,
   output logic             Ram_RW,
   output logic [15:0]      Ram_Address,
   output logic [31:0]      Instruction,
   output logic             Memory_Enable,
   output logic             Reg_Write,
   output logic [3:0]       Flag,
   output logic [PC_W-1:0]  PC,
   output logic [CNT_W-1:0] Retired,
   output logic             Halted
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM1, S_MEM2, S_WB, S_HALT
   } state_t;

   localparam logic [3:0] OP_LDR  = 4'b1100;
   localparam logic [3:0] OP_STR  = 4'b1101;
   localparam logic [3:0] OP_B    = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   state_t            state;
   logic [3:0]        cond;
   logic [3:0]        opcode;
   logic              s_bit;
   logic              is_ldr;
   logic              is_str;
   logic              cond_ok;
   logic [PC_W-1:0]   next_pc;
   logic [PC_W-1:0]   branch_pc;
   logic [CNT_W-1:0]  retired_next;
   logic              n_f, z_f, c_f, v_f;

   assign cond      = Instruction[31:28];
   assign opcode    = Instruction[27:24];
   assign s_bit     = Instruction[23];
   assign is_ldr    = (opcode == OP_LDR);
   assign is_str    = (opcode == OP_STR);
   assign next_pc   = PC + PC_W'(1);
   assign branch_pc = Instruction[3 +: PC_W];
   assign {n_f, z_f, c_f, v_f} = Flag;

   // Retired saturates rather than wrapping so a long run never reads as a short one.
   assign retired_next = (Retired == {CNT_W{1'b1}}) ? Retired : Retired + CNT_W'(1);

   // The RAM port follows the data address only while the MEM phase is active.
   assign Ram_Address = Memory_Enable ? Mem_Address : 16'(PC);

   always_comb begin
      cond_ok = 1'b0;
      case (cond)
         4'b0000: cond_ok = z_f;
         4'b0001: cond_ok = !z_f;
         4'b0010: cond_ok = c_f;
         4'b0011: cond_ok = !c_f;
         4'b0100: cond_ok = n_f;
         4'b0101: cond_ok = !n_f;
         4'b0110: cond_ok = v_f;
         4'b0111: cond_ok = !v_f;
         4'b1010: cond_ok = (n_f == v_f);
         4'b1011: cond_ok = (n_f != v_f);
         4'b1100: cond_ok = !z_f && (n_f == v_f);
         4'b1101: cond_ok = z_f || (n_f != v_f);
         4'b1110: cond_ok = 1'b1;
         default: cond_ok = 1'b0;
      endcase
   end

   // Strobes are registered: each transition loads the strobe values of the state being entered.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state         <= S_IDLE;
         Ram_Enable    <= 1'b0;
         Ram_RW        <= 1'b0;
         Memory_Enable <= 1'b0;
         Reg_Write     <= 1'b0;
         Halted        <= 1'b0;
         Instruction   <= '0;
         Flag          <= '0;
         PC            <= '0;
         Retired       <= '0;
      end else begin
         Ram_Enable    <= 1'b0;
         Ram_RW        <= 1'b0;
         Memory_Enable <= 1'b0;
         Reg_Write     <= 1'b0;
         Halted        <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  state      <= S_FETCH;
                  PC         <= '0;
                  Ram_Enable <= 1'b1;
                  Ram_RW     <= 1'b1;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               Instruction <= Ram_Out;
               state       <= S_EXEC;
            end
            S_EXEC: begin
               if (!cond_ok) begin
                  PC         <= next_pc;
                  state      <= S_FETCH;
                  Ram_Enable <= 1'b1;
                  Ram_RW     <= 1'b1;
               end else if (opcode == OP_HALT) begin
                  state  <= S_HALT;
                  Halted <= 1'b1;
               end else if (opcode == OP_B) begin
                  PC         <= branch_pc;
                  Retired    <= retired_next;
                  state      <= S_FETCH;
                  Ram_Enable <= 1'b1;
                  Ram_RW     <= 1'b1;
               end else if (is_ldr || is_str) begin
                  state         <= S_MEM1;
                  Memory_Enable <= 1'b1;
                  Ram_Enable    <= 1'b1;
                  Ram_RW        <= !is_str;
               end else begin
                  state     <= S_WB;
                  Reg_Write <= 1'b1;
               end
            end
            // Second MEM cycle: a store has already written, so the port just reads.
            S_MEM1: begin
               state         <= S_MEM2;
               Memory_Enable <= 1'b1;
               Ram_Enable    <= 1'b1;
               Ram_RW        <= 1'b1;
            end
            S_MEM2: begin
               if (is_str) begin
                  PC         <= next_pc;
                  Retired    <= retired_next;
                  state      <= S_FETCH;
                  Ram_Enable <= 1'b1;
                  Ram_RW     <= 1'b1;
               end else begin
                  state     <= S_WB;
                  Reg_Write <= 1'b1;
               end
            end
            S_WB: begin
               if (s_bit && !is_ldr)
                  Flag <= New_Flag;
               PC         <= next_pc;
               Retired    <= retired_next;
               state      <= S_FETCH;
               Ram_Enable <= 1'b1;
               Ram_RW     <= 1'b1;
            end
            S_HALT: Halted <= 1'b1;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of single-instruction vectors behind a
// flag-setup instruction, plus directed reset, branch-wrap and halt sequences.
module tb_instr_sequencer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [31:0] Ram_Out;
   logic [15:0] Mem_Address;
   logic [3:0]  New_Flag;
   logic        Ram_Enable;
   logic        Ram_RW;
   logic [15:0] Ram_Address;
   logic [31:0] Instruction;
   logic        Memory_Enable;
   logic        Reg_Write;
   logic [3:0]  Flag;
   logic [7:0]  PC;
   logic [15:0] Retired;
   logic        Halted;

   logic [31:0] ram [256];

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [3:0]  setup;
      logic [31:0] word;
      logic [3:0]  nf;
      int          cyc;
      int          rw;
      int          rwcyc;
      int          wr;
      int          memen;
      logic [3:0]  flag;
      logic [7:0]  pc;
      logic [15:0] ret;
      logic        halt;
   } vec_t;

   vec_t vecs [18];

   always #5 Clk = ~Clk;

   instr_sequencer #(.PC_W(8), .CNT_W(16)) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .Start         (Start),
      .Ram_Out       (Ram_Out),
      .Mem_Address   (Mem_Address),
      .New_Flag      (New_Flag),
      .Ram_Enable    (Ram_Enable),
      .Ram_RW        (Ram_RW),
      .Ram_Address   (Ram_Address),
      .Instruction   (Instruction),
      .Memory_Enable (Memory_Enable),
      .Reg_Write     (Reg_Write),
      .Flag          (Flag),
      .PC            (PC),
      .Retired       (Retired),
      .Halted        (Halted)
   );

   // Synchronous-read RAM: data appears the cycle after a read strobe.
   always @(posedge Clk) begin
      if (Ram_Enable && Ram_RW)
         Ram_Out <= ram[Ram_Address[7:0]];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic clearRam();
      for (int i = 0; i < 256; i++)
         ram[i] = 32'h0;
   endtask

   task automatic doReset();
      Reset = 1'b0;
      Start = 1'b0;
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
   endtask

   task automatic pulseStart();
      Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
   endtask

   // Runs a flag-setup ALU op at address 0, then the vector's word at address 1.
   task automatic applyStimulus(input vec_t v, input int idx);
      int    guard, cyc, rw, rwcyc, wr, memen, badaddr, clash;
      string tag;
      tag = $sformatf("v%0d", idx);
      doReset();
      clearRam();
      ram[0]      = 32'hE0800000;
      ram[1]      = v.word;
      New_Flag    = v.setup;
      Mem_Address = 16'h0040;
      pulseStart();
      guard = 0;
      while (PC !== 8'd1 && guard < 20) begin
         @(negedge Clk);
         guard++;
      end
      checkOutput({tag, " setup_reached"}, 32'(guard < 20), 32'd1);
      New_Flag = v.nf;
      cyc = 0; rw = 0; rwcyc = 0; wr = 0; memen = 0; badaddr = 0; clash = 0;
      while (PC === 8'd1 && Halted !== 1'b1 && cyc < 20) begin
         cyc++;
         if (Reg_Write) begin
            rw++;
            rwcyc = cyc;
         end
         if (Ram_Enable && !Ram_RW) begin
            wr++;
            if (Ram_Address !== 16'h0040) badaddr++;
            if (Reg_Write) clash++;
         end
         if (Memory_Enable) memen++;
         @(negedge Clk);
      end
      checkOutput({tag, " cycles"},      32'(cyc),     32'(v.cyc));
      checkOutput({tag, " reg_writes"},  32'(rw),      32'(v.rw));
      checkOutput({tag, " rw_cycle"},    32'(rwcyc),   32'(v.rwcyc));
      checkOutput({tag, " ram_writes"},  32'(wr),      32'(v.wr));
      checkOutput({tag, " mem_enable"},  32'(memen),   32'(v.memen));
      checkOutput({tag, " write_addr"},  32'(badaddr), 32'd0);
      checkOutput({tag, " write_clash"}, 32'(clash),   32'd0);
      checkOutput({tag, " flag"},        32'(Flag),    32'(v.flag));
      checkOutput({tag, " pc"},          32'(PC),      32'(v.pc));
      checkOutput({tag, " retired"},     32'(Retired), 32'(v.ret));
      checkOutput({tag, " halted"},      32'(Halted),  32'(v.halt));
   endtask

   initial begin
      int guard, bad;
      //            setup  word           nf    cyc rw rwc wr me  flag  pc    ret    halt
      vecs[0]  = '{4'h0, 32'hE0800000, 4'h4, 4, 1, 4, 0, 0, 4'h4, 8'd2, 16'd2, 1'b0};
      vecs[1]  = '{4'h4, 32'hE0000000, 4'hF, 4, 1, 4, 0, 0, 4'h4, 8'd2, 16'd2, 1'b0};
      vecs[2]  = '{4'h0, 32'h00800000, 4'hF, 3, 0, 0, 0, 0, 4'h0, 8'd2, 16'd1, 1'b0};
      vecs[3]  = '{4'h4, 32'h00800000, 4'h1, 4, 1, 4, 0, 0, 4'h1, 8'd2, 16'd2, 1'b0};
      vecs[4]  = '{4'h4, 32'h10800000, 4'hF, 3, 0, 0, 0, 0, 4'h4, 8'd2, 16'd1, 1'b0};
      vecs[5]  = '{4'h2, 32'h20800000, 4'h4, 4, 1, 4, 0, 0, 4'h4, 8'd2, 16'd2, 1'b0};
      vecs[6]  = '{4'h8, 32'h40800000, 4'h6, 4, 1, 4, 0, 0, 4'h6, 8'd2, 16'd2, 1'b0};
      vecs[7]  = '{4'h0, 32'h60800000, 4'hF, 3, 0, 0, 0, 0, 4'h0, 8'd2, 16'd1, 1'b0};
      vecs[8]  = '{4'h9, 32'hA0800000, 4'h2, 4, 1, 4, 0, 0, 4'h2, 8'd2, 16'd2, 1'b0};
      vecs[9]  = '{4'h9, 32'hB0800000, 4'hF, 3, 0, 0, 0, 0, 4'h9, 8'd2, 16'd1, 1'b0};
      vecs[10] = '{4'h0, 32'hC0800000, 4'h8, 4, 1, 4, 0, 0, 4'h8, 8'd2, 16'd2, 1'b0};
      vecs[11] = '{4'h4, 32'hC0800000, 4'hF, 3, 0, 0, 0, 0, 4'h4, 8'd2, 16'd1, 1'b0};
      vecs[12] = '{4'h8, 32'hD0800000, 4'h0, 4, 1, 4, 0, 0, 4'h0, 8'd2, 16'd2, 1'b0};
      vecs[13] = '{4'hF, 32'h80800000, 4'h0, 3, 0, 0, 0, 0, 4'hF, 8'd2, 16'd1, 1'b0};
      vecs[14] = '{4'h2, 32'hED800000, 4'hF, 5, 0, 0, 1, 2, 4'h2, 8'd2, 16'd2, 1'b0};
      vecs[15] = '{4'h2, 32'hEC800000, 4'hF, 6, 1, 6, 0, 2, 4'h2, 8'd2, 16'd2, 1'b0};
      vecs[16] = '{4'h0, 32'h4C000000, 4'hF, 3, 0, 0, 0, 0, 4'h0, 8'd2, 16'd1, 1'b0};
      vecs[17] = '{4'h5, 32'hEF000000, 4'hF, 3, 0, 0, 0, 0, 4'h5, 8'd1, 16'd1, 1'b1};

      Reset       = 1'b0;
      Start       = 1'b0;
      New_Flag    = 4'h0;
      Mem_Address = 16'h0040;
      clearRam();
      #1;
      checkOutput("reset_ram_enable", 32'(Ram_Enable), 32'd0);
      checkOutput("reset_pc",         32'(PC),         32'd0);
      checkOutput("reset_halted",     32'(Halted),     32'd0);

      // Idle with reset released and no Start: nothing touches the RAM.
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge Clk);
         if (Ram_Enable !== 1'b0 || Reg_Write !== 1'b0 || PC !== 8'd0) bad++;
      end
      checkOutput("idle_quiet", 32'(bad), 32'd0);

      for (int i = 0; i < 18; i++)
         applyStimulus(vecs[i], i);

      // Reset asserted mid-FETCH after a flag-setting instruction has committed.
      applyStimulus(vecs[0], 100);
      checkOutput("midfetch_in_fetch", 32'(Ram_Enable && Ram_RW), 32'd1);
      Reset = 1'b0;
      #1;
      checkOutput("midfetch_ram_enable",  32'(Ram_Enable),    32'd0);
      checkOutput("midfetch_ram_rw",      32'(Ram_RW),        32'd0);
      checkOutput("midfetch_pc",          32'(PC),            32'd0);
      checkOutput("midfetch_instruction", Instruction,        32'd0);
      checkOutput("midfetch_flag",        32'(Flag),          32'd0);
      checkOutput("midfetch_retired",     32'(Retired),       32'd0);
      checkOutput("midfetch_ram_address", 32'(Ram_Address),   32'd0);
      checkOutput("midfetch_strobes",     32'({Memory_Enable, Reg_Write, Halted}), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;

      // Branch to 0xFF, then an ALU op there wraps PC to 0.
      doReset();
      clearRam();
      ram[0]   = 32'hEE0007F8;
      ram[255] = 32'hE0000000;
      pulseStart();
      guard = 0;
      while (PC !== 8'hFF && guard < 20) begin
         @(negedge Clk);
         guard++;
      end
      checkOutput("branch_cycles",  32'(guard),   32'd3);
      checkOutput("branch_retired", 32'(Retired), 32'd1);
      guard = 0;
      while (PC !== 8'h00 && guard < 20) begin
         @(negedge Clk);
         guard++;
      end
      checkOutput("wrap_cycles",  32'(guard),   32'd4);
      checkOutput("wrap_pc",      32'(PC),      32'd0);
      checkOutput("wrap_retired", 32'(Retired), 32'd2);

      // HALT at PC=3 holds with strobes low and ignores Start.
      doReset();
      clearRam();
      ram[0] = 32'hE0000000;
      ram[1] = 32'hE0000000;
      ram[2] = 32'hE0000000;
      ram[3] = 32'hEF000000;
      pulseStart();
      guard = 0;
      while (Halted !== 1'b1 && guard < 60) begin
         @(negedge Clk);
         guard++;
      end
      checkOutput("halt_cycles",  32'(guard),   32'd15);
      checkOutput("halt_pc",      32'(PC),      32'd3);
      checkOutput("halt_retired", 32'(Retired), 32'd3);
      bad = 0;
      for (int i = 0; i < 25; i++) begin
         Start = i[0];
         @(negedge Clk);
         if (Ram_Enable || Reg_Write || Memory_Enable || Halted !== 1'b1 || PC !== 8'd3) bad++;
      end
      Start = 1'b0;
      checkOutput("halt_hold", 32'(bad), 32'd0);
      Reset = 1'b0;
      #1;
      checkOutput("halt_reset_halted", 32'(Halted),  32'd0);
      checkOutput("halt_reset_pc",     32'(PC),      32'd0);
      checkOutput("halt_reset_retired",32'(Retired), 32'd0);
      @(negedge Clk);
      Reset = 1'b1;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge Clk);
         if (Ram_Enable !== 1'b0 || Halted !== 1'b0) bad++;
      end
      checkOutput("halt_reset_idle", 32'(bad), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
